operand_register_file: RTL and testbench

Eight-entry, 16-bit register file with a one-deep operand output register that issues operand pairs to the function unit and accepts its results back. It sits directly upstream of the function unit and provides A, B and the 4-bit function-select code. It also takes the write-back of results and latches the Overflow/CarryOut/Negative/Zero flags. Operands move out over a valid/ready handshake, so the function-unit stage can stall without losing an issued operation.

---
 rtl/operand_register_file.sv | 103 ++++++++++
 tb/tb_operand_register_file.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_register_file.sv
// Eight-entry register file with a one-deep valid/ready operand register feeding the function unit.
// Define WRITE_BYPASS_EN to forward same-cycle write-back data into issued operands.
module operand_register_file #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_issue_valid,
    output logic                 o_issue_ready,
    input  logic [ADDR_BITS-1:0] i_addr_a,
    input  logic [ADDR_BITS-1:0] i_addr_b,
    input  logic [WIDTH-1:0]     i_constant_in,
    input  logic                 i_mux_b_select,
    input  logic [3:0]           i_function_select_in,
    input  logic [ADDR_BITS-1:0] i_dest_addr_in,
    output logic                 o_operand_valid,
    input  logic                 i_operand_ready,
    output logic [WIDTH-1:0]     o_a,
    output logic [WIDTH-1:0]     o_b,
    output logic [3:0]           o_function_select,
    output logic [ADDR_BITS-1:0] o_dest_addr,
    input  logic                 i_write_enable,
    input  logic [ADDR_BITS-1:0] i_write_addr,
    input  logic [WIDTH-1:0]     i_write_data,
    input  logic                 i_status_write,
    input  logic [3:0]           i_flags_in,
    output logic [3:0]           o_status
);

    localparam int unsigned NUM_REGS = 1 << ADDR_BITS;

    logic [WIDTH-1:0]     r_regs [NUM_REGS];
    logic                 r_operand_valid;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [3:0]           r_function_select;
    logic [ADDR_BITS-1:0] r_dest_addr;
    logic [3:0]           r_status;

    logic                 w_issue_ready;
    logic                 w_issue_fire;
    logic [WIDTH-1:0]     w_read_a;
    logic [WIDTH-1:0]     w_read_b;
    logic [WIDTH-1:0]     w_operand_b;

    assign w_issue_ready = !r_operand_valid || i_operand_ready;
    assign w_issue_fire  = i_issue_valid && w_issue_ready;

    always_comb begin
        w_read_a = r_regs[i_addr_a];
        w_read_b = r_regs[i_addr_b];
`ifdef WRITE_BYPASS_EN
        if (i_write_enable && (i_write_addr == i_addr_a)) begin
            w_read_a = i_write_data;
        end
        if (i_write_enable && (i_write_addr == i_addr_b)) begin
            w_read_b = i_write_data;
        end
`endif
        w_operand_b = i_mux_b_select ? i_constant_in : w_read_b;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_operand_valid   <= 1'b0;
            r_a               <= '0;
            r_b               <= '0;
            r_function_select <= '0;
            r_dest_addr       <= '0;
            r_status          <= '0;
        end else begin
            if (i_write_enable) begin
                r_regs[i_write_addr] <= i_write_data;
            end
            if (i_status_write) begin
                r_status <= i_flags_in;
            end
            // Operand fields only change on an accepted issue; a drain just clears valid.
            if (w_issue_fire) begin
                r_operand_valid   <= 1'b1;
                r_a               <= w_read_a;
                r_b               <= w_operand_b;
                r_function_select <= i_function_select_in;
                r_dest_addr       <= i_dest_addr_in;
            end else if (r_operand_valid && i_operand_ready) begin
                r_operand_valid <= 1'b0;
            end
        end
    end

    assign o_issue_ready     = w_issue_ready;
    assign o_operand_valid   = r_operand_valid;
    assign o_a               = r_a;
    assign o_b               = r_b;
    assign o_function_select = r_function_select;
    assign o_dest_addr       = r_dest_addr;
    assign o_status          = r_status;

endmodule

// File: tb/tb_operand_register_file.sv
// Directed bench for operand_register_file: vector table plus hand-written stall, bypass,
// status and reset-in-stall sequences.
module tb_operand_register_file;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  addr_a;
    logic [2:0]  addr_b;
    logic [15:0] constant_in;
    logic        mux_b_select;
    logic [3:0]  fsel_in;
    logic [2:0]  dest_in;
    logic        operand_valid;
    logic        operand_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fsel;
    logic [2:0]  dest;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        status_write;
    logic [3:0]  flags_in;
    logic [3:0]  status;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    operand_register_file #(
        .WIDTH     (16),
        .ADDR_BITS (3)
    ) dut (
        .i_clock              (clk),
        .i_reset_n            (reset_n),
        .i_issue_valid        (issue_valid),
        .o_issue_ready        (issue_ready),
        .i_addr_a             (addr_a),
        .i_addr_b             (addr_b),
        .i_constant_in        (constant_in),
        .i_mux_b_select       (mux_b_select),
        .i_function_select_in (fsel_in),
        .i_dest_addr_in       (dest_in),
        .o_operand_valid      (operand_valid),
        .i_operand_ready      (operand_ready),
        .o_a                  (a),
        .o_b                  (b),
        .o_function_select    (fsel),
        .o_dest_addr          (dest),
        .i_write_enable       (write_enable),
        .i_write_addr         (write_addr),
        .i_write_data         (write_data),
        .i_status_write       (status_write),
        .i_flags_in           (flags_in),
        .o_status             (status)
    );

    typedef struct {
        logic        iv;
        logic [2:0]  aa;
        logic [2:0]  ab;
        logic [15:0] k;
        logic        mux;
        logic [3:0]  fs;
        logic [2:0]  dst;
        logic        ordy;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [3:0]  efs;
        logic [2:0]  ed;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        issue_valid   = 1'b0;
        addr_a        = '0;
        addr_b        = '0;
        constant_in   = '0;
        mux_b_select  = 1'b0;
        fsel_in       = '0;
        dest_in       = '0;
        operand_ready = 1'b1;
        write_enable  = 1'b0;
        write_addr    = '0;
        write_data    = '0;
        status_write  = 1'b0;
        flags_in      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] aa, input logic [2:0] ab, input logic mux,
                         input logic [15:0] k, input logic [3:0] fs, input logic [2:0] dst);
        issue_valid  = 1'b1;
        addr_a       = aa;
        addr_b       = ab;
        mux_b_select = mux;
        constant_in  = k;
        fsel_in      = fs;
        dest_in      = dst;
    endtask

    task automatic write_reg(input logic [2:0] wa, input logic [15:0] wd);
        write_enable = 1'b1;
        write_addr   = wa;
        write_data   = wd;
    endtask

    vec_t vecs [8];
    logic prev_valid;
    logic [15:0] exp_bypass;

    initial begin
        vecs[0] = '{1, 0, 1, 16'h0000, 0, 4'h0, 0, 1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 4'h0, 0};
        vecs[1] = '{0, 0, 0, 16'h0000, 0, 4'h0, 0, 1, 1, 3, 16'h1234, 0, 16'h0000, 16'h0000, 4'h0, 0};
        vecs[2] = '{0, 0, 0, 16'h0000, 0, 4'h0, 0, 1, 1, 5, 16'hFFFF, 0, 16'h0000, 16'h0000, 4'h0, 0};
        vecs[3] = '{1, 3, 5, 16'h0000, 0, 4'h2, 6, 1, 0, 0, 16'h0000, 1, 16'h1234, 16'hFFFF, 4'h2, 6};
        vecs[4] = '{1, 3, 5, 16'h00A5, 1, 4'h1, 2, 1, 0, 0, 16'h0000, 1, 16'h1234, 16'h00A5, 4'h1, 2};
        vecs[5] = '{1, 5, 3, 16'h0000, 0, 4'hF, 7, 1, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h1234, 4'hF, 7};
        vecs[6] = '{0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h1234, 4'hF, 7};
        vecs[7] = '{0, 0, 0, 16'h0000, 0, 4'h0, 0, 1, 0, 0, 16'h0000, 0, 16'hFFFF, 16'h1234, 4'hF, 7};

        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        check("reset_valid", operand_valid, 0);
        check("reset_issue_ready", issue_ready, 1);
        check("reset_status", status, 0);
        check("reset_a", a, 0);
        reset_n = 1'b1;

        // Table: one row per cycle, issue_ready checked before the edge, outputs after.
        prev_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue_valid   = vecs[i].iv;
            addr_a        = vecs[i].aa;
            addr_b        = vecs[i].ab;
            constant_in   = vecs[i].k;
            mux_b_select  = vecs[i].mux;
            fsel_in       = vecs[i].fs;
            dest_in       = vecs[i].dst;
            operand_ready = vecs[i].ordy;
            write_enable  = vecs[i].we;
            write_addr    = vecs[i].wa;
            write_data    = vecs[i].wd;
            #1;
            check($sformatf("vec%0d_issue_ready", i), issue_ready, !prev_valid || vecs[i].ordy);
            tick();
            check($sformatf("vec%0d_valid", i), operand_valid, vecs[i].ev);
            check($sformatf("vec%0d_a", i), a, vecs[i].ea);
            check($sformatf("vec%0d_b", i), b, vecs[i].eb);
            check($sformatf("vec%0d_fsel", i), fsel, vecs[i].efs);
            check($sformatf("vec%0d_dest", i), dest, vecs[i].ed);
            prev_valid = vecs[i].ev;
        end
        check("status_after_table", status, 0);

        // Stall: load R3/R5, then hold OperandReady low with a pending issue and a write to R3.
        idle_inputs();
        issue(3, 5, 0, 16'h0, 4'h2, 6);
        tick();
        check("stall_load_a", a, 16'h1234);
        issue(5, 3, 0, 16'h0, 4'h7, 1);
        operand_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) write_reg(3, 16'h5555);
            else write_enable = 1'b0;
            #1;
            check($sformatf("stall%0d_issue_ready", c), issue_ready, 0);
            tick();
            check($sformatf("stall%0d_valid", c), operand_valid, 1);
            check($sformatf("stall%0d_a", c), a, 16'h1234);
            check($sformatf("stall%0d_b", c), b, 16'hFFFF);
            check($sformatf("stall%0d_fsel", c), fsel, 4'h2);
        end
        operand_ready = 1'b1;
        #1;
        check("unstall_issue_ready", issue_ready, 1);
        tick();
        check("unstall_valid", operand_valid, 1);
        check("unstall_a", a, 16'hFFFF);
        check("unstall_b", b, 16'h5555);
        check("unstall_fsel", fsel, 4'h7);
        check("unstall_dest", dest, 1);

        // Same-cycle write and issue to R2.
        idle_inputs();
        write_reg(2, 16'h0001);
        tick();
        idle_inputs();
        write_reg(2, 16'hBEEF);
        issue(2, 2, 0, 16'h0, 4'h3, 2);
        tick();
`ifdef WRITE_BYPASS_EN
        exp_bypass = 16'hBEEF;
`else
        exp_bypass = 16'h0001;
`endif
        check("bypass_a", a, exp_bypass);
        check("bypass_b", b, exp_bypass);
        idle_inputs();
        issue(2, 2, 0, 16'h0, 4'h3, 2);
        tick();
        check("after_write_a", a, 16'hBEEF);
        check("after_write_b", b, 16'hBEEF);

        // Status capture and hold.
        idle_inputs();
        status_write = 1'b1;
        flags_in     = 4'b1011;
        tick();
        check("status_capture", status, 4'b1011);
        status_write = 1'b0;
        flags_in     = 4'b0100;
        tick();
        check("status_hold", status, 4'b1011);

        // Reset in the middle of a stall, with write, issue and status write all discarded.
        idle_inputs();
        issue(3, 5, 0, 16'h0, 4'h9, 4);
        tick();
        operand_ready = 1'b0;
        issue_valid   = 1'b0;
        tick();
        check("prereset_valid", operand_valid, 1);
        reset_n = 1'b0;
        issue(1, 2, 1, 16'h7777, 4'hE, 5);
        write_reg(4, 16'h7777);
        status_write = 1'b1;
        flags_in     = 4'b1111;
        tick();
        check("rst_stall_valid", operand_valid, 0);
        check("rst_stall_status", status, 0);
        check("rst_stall_a", a, 0);
        check("rst_stall_b", b, 0);
        check("rst_stall_fsel", fsel, 0);
        check("rst_stall_issue_ready", issue_ready, 1);
        reset_n = 1'b1;
        idle_inputs();
        issue(3, 5, 0, 16'h0, 4'h1, 1);
        tick();
        check("post_rst_r3", a, 0);
        check("post_rst_r5", b, 0);
        issue(4, 2, 0, 16'h0, 4'h1, 1);
        tick();
        check("post_rst_r4", a, 0);
        check("post_rst_r2", b, 0);
        check("post_rst_status", status, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
